// File: rtl/qdiv_seq.sv
// Sequential sign-magnitude Qm.Q divider: restoring long division,
// one quotient bit per clock, start/done handshake.
module qdiv_seq #(
  parameter int N = 32,
  parameter int Q = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] c,
  output logic         ovf,
  output logic         dz
);

  localparam int W  = N - 1 + Q;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   dvd_q, dvd_d;
  logic [N-2:0]   rem_q, rem_d;
  logic [N-2:0]   div_q, div_d;
  logic [W-2:0]   qt_q, qt_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           sign_q, sign_d;
  logic [N-1:0]   c_q, c_d;
  logic           ovf_q, ovf_d;
  logic           dz_q, dz_d;

  logic [N-1:0]   rem_sh;
  logic           qbit;
  logic [W-1:0]   qt_full;
  logic [N-2:0]   mag;

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    div_d   = div_q;
    qt_d    = qt_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    c_d     = c_q;
    ovf_d   = ovf_q;
    dz_d    = dz_q;
    mag     = '0;
    rem_sh  = {rem_q, dvd_q[W-1]};
    qbit    = (rem_sh >= {1'b0, div_q});
    // the final quotient bit is folded in combinationally so the result
    // can be registered on the same edge as the last iteration
    qt_full = {qt_q, qbit};

    case (state_q)
      IDLE: begin
        if (start) begin
          sign_d = a[N-1] ^ b[N-1];
          div_d  = b[N-2:0];
          ovf_d  = 1'b0;
          dz_d   = 1'b0;
          c_d    = '0;
          if (b[N-2:0] == '0) begin
            dz_d    = 1'b1;
            c_d     = {a[N-1], {(N-1){1'b1}}};
            state_d = DONE;
          end else begin
            dvd_d   = {a[N-2:0], {Q{1'b0}}};
            rem_d   = '0;
            qt_d    = '0;
            cnt_d   = CW'(W - 1);
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        dvd_d = {dvd_q[W-2:0], 1'b0};
        rem_d = qbit ? (rem_sh[N-2:0] - div_q) : rem_sh[N-2:0];
        qt_d  = qt_full[W-2:0];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          ovf_d   = |qt_full[W-1:N-1];
          mag     = (|qt_full[W-1:N-1]) ? '1 : qt_full[N-2:0];
          c_d     = {sign_q & (|mag), mag};
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      rem_q   <= '0;
      div_q   <= '0;
      qt_q    <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      c_q     <= '0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      qt_q    <= qt_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      c_q     <= c_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
    end
  end

  assign busy = (state_q == BUSY);
  assign done = (state_q == DONE);
  assign c    = c_q;
  assign ovf  = ovf_q;
  assign dz   = dz_q;

endmodule

// File: tb/tb_qdiv_seq.sv
// Self-checking bench for qdiv_seq: arithmetic reference model with a
// latency timeline, directed cases and randomized start/operand traffic.
module tb_qdiv_seq;
  localparam int N = 32;
  localparam int Q = 15;
  localparam int W = N - 1 + Q;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         busy, done, ovf, dz;
  logic [N-1:0] c;

  always #5 clk = ~clk;

  qdiv_seq #(.N(N), .Q(Q)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .c(c), .ovf(ovf), .dz(dz)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Result as {dz, ovf, c} from plain integer division of the magnitudes.
  function automatic logic [N+1:0] model_div(input logic [N-1:0] x, input logic [N-1:0] y);
    longint unsigned num, den, q;
    logic [N-2:0] m;
    logic s;
    num = longint'(x[N-2:0]) << Q;
    den = longint'(y[N-2:0]);
    if (den == 0) return {1'b1, 1'b0, x[N-1], {(N-1){1'b1}}};
    q = num / den;
    if (q > 64'h7FFF_FFFF) begin
      m = '1;
      return {1'b0, 1'b1, x[N-1] ^ y[N-1], m};
    end
    m = q[N-2:0];
    s = (m != 0) && (x[N-1] ^ y[N-1]);
    return {1'b0, 1'b0, s, m};
  endfunction

  // Timeline model: 0 idle, 1 computing (W cycles), 2 result-ready pulse.
  int            m_phase = 0;
  int            m_left = 0;
  logic [N+1:0]  m_res;
  logic [N-1:0]  m_c = '0;
  logic          m_ovf = 1'b0;
  logic          m_dz = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_phase = 0; m_c = '0; m_ovf = 1'b0; m_dz = 1'b0;
    end else begin
      case (m_phase)
        0: if (start) begin
          m_res = model_div(a, b);
          m_c = '0; m_ovf = 1'b0; m_dz = 1'b0;
          if (m_res[N+1]) begin
            {m_dz, m_ovf, m_c} = m_res;
            m_phase = 2;
          end else begin
            m_left = W;
            m_phase = 1;
          end
        end
        1: begin
          m_left--;
          if (m_left == 0) begin
            {m_dz, m_ovf, m_c} = m_res;
            m_phase = 2;
          end
        end
        default: m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy, m_phase == 1);
      chk("done", done, m_phase == 2);
      chk("c",    c,    m_c);
      chk("ovf",  ovf,  m_ovf);
      chk("dz",   dz,   m_dz);
    end
  end

  task automatic run_div(input logic [N-1:0] ta, input logic [N-1:0] tb_in,
                         input logic [N-1:0] ec, input logic eo, input logic ed,
                         input int poke, input int exp_lat, input string tag);
    int n, nb;
    chk({tag, "_model"}, model_div(ta, tb_in), {ed, eo, ec});
    @(negedge clk);
    a = ta; b = tb_in; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1; nb = 0;
    while (!done && n < 100) begin
      if (busy) nb++;
      start = (n == poke);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk({tag, "_latency"}, n, exp_lat);
    chk({tag, "_busy_cycles"}, nb, exp_lat - 1);
    chk({tag, "_c"}, c, ec);
    chk({tag, "_ovf"}, ovf, eo);
    chk({tag, "_dz"}, dz, ed);
  endtask

  logic [N-1:0] rv;
  logic         rs;
  int           nd;

  initial begin
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    run_div(32'h0000C000, 32'h00004000, 32'h00018000, 1'b0, 1'b0, -1, W + 1, "pos_3");
    run_div(32'h8000C000, 32'h00004000, 32'h80018000, 1'b0, 1'b0, -1, W + 1, "neg_3");
    run_div(32'h8000C000, 32'h80004000, 32'h00018000, 1'b0, 1'b0, -1, W + 1, "negneg_3");
    run_div(32'h00008000, 32'h00000000, 32'h7FFFFFFF, 1'b0, 1'b1, -1, 1, "dz_pos");
    run_div(32'h80008000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b1, -1, 1, "dz_neg");
    run_div(32'h7FFFFFFF, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b0, -1, W + 1, "ovf");
    run_div(32'h00008000, 32'h00018000, 32'h00002AAA, 1'b0, 1'b0, -1, W + 1, "third");
    run_div(32'h80000000, 32'h00008000, 32'h00000000, 1'b0, 1'b0, -1, W + 1, "negzero");
    run_div(32'h00000001, 32'h7FFFFFFF, 32'h00000000, 1'b0, 1'b0, -1, W + 1, "tiny");
    run_div(32'h0000C000, 32'h00004000, 32'h00018000, 1'b0, 1'b0, 10, W + 1, "poke");

    // abandon a division with a one-cycle reset
    @(negedge clk);
    a = 32'h0000C000; b = 32'h00004000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_c", c, 32'h0);
    nd = 0;
    repeat (60) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("rst_no_done", nd, 0);
    run_div(32'h0000C000, 32'h00004000, 32'h00018000, 1'b0, 1'b0, -1, W + 1, "after_rst");

    repeat (8000) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      rv = $urandom;
      case ($urandom_range(0, 3))
        0: a = rv >> $urandom_range(0, 31);
        1: a = rv & 32'h8000FFFF;
        default: a = rv;
      endcase
      rv = $urandom;
      rs = rv[31];
      case ($urandom_range(0, 5))
        0: b = {rs, 31'h0};
        1: b = rv >> $urandom_range(8, 31);
        2: b = rv & 32'h8000FFFF;
        default: b = rv >> $urandom_range(0, 16);
      endcase
    end
    start = 1'b0;
    repeat (60) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
